// File: rtl/instr_byte_aligner_if.sv
// Bus bundle between the instruction-byte FIFO, the byte aligner and decode.
// master: the aligner (pops the FIFO, drives the instruction toward decode).
// slave : the environment (FIFO head view, flush source, decode acceptance).
interface instr_byte_aligner_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MULTI_POP  = 8,
  parameter int MAX_LEN    = 4,
  parameter int CNT_W      = $clog2(MULTI_POP)
);
  // FIFO head view; entry 0 is the oldest byte
  logic [MULTI_POP-1:0][DATA_WIDTH-1:0] fifo_data;
  logic [CNT_W-1:0]                     fifo_ready_cnt;
  logic [CNT_W-1:0]                     fifo_poll_cnt;
  // pipeline flush
  logic                                 flush;
  // instruction toward decode
  logic [MAX_LEN*DATA_WIDTH-1:0]        instr_data;
  logic [2:0]                           instr_len;
  logic                                 instr_valid;
  logic                                 instr_ready;

  modport master (
    input  fifo_data, fifo_ready_cnt, flush, instr_ready,
    output fifo_poll_cnt, instr_data, instr_len, instr_valid
  );

  modport slave (
    output fifo_data, fifo_ready_cnt, flush, instr_ready,
    input  fifo_poll_cnt, instr_data, instr_len, instr_valid
  );
endinterface

// File: rtl/instr_byte_aligner.sv
// Instruction byte aligner: decodes the length of the instruction at the
// FIFO head from the low two bits of byte 0, pops the whole instruction in
// one cycle once all of its bytes are visible, and registers it toward
// decode over valid/ready. A flush drains the FIFO until it reports empty.
// Optional macro INSTR_ALIGNER_PERF_EN adds stall_cycles / instr_count
// saturating performance counters.
module instr_byte_aligner #(
  parameter int DATA_WIDTH = 8,
  parameter int MULTI_POP  = 8,
  parameter int MAX_LEN    = 4,
  parameter int CNT_W      = $clog2(MULTI_POP)
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_byte_aligner_if.master  bus
`ifdef INSTR_ALIGNER_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           instr_count
`endif
);

  typedef enum logic {RUN, DRAIN} state_t;

  localparam int IW = MAX_LEN * DATA_WIDTH;

  state_t                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic [IW-1:0]           data_q, data_d;
  logic [2:0]              len_q, len_d;
  logic [CNT_W-1:0]        poll_cnt;

  logic [2:0]              len_dec;
  logic [CNT_W-1:0]        len_cnt;
  logic                    head_avail;
  logic                    slot_free;
  logic                    load;
  logic                    starve;

  // Entries beyond MAX_LEN are never needed to assemble an instruction.
  logic                    unused_hi;
  assign unused_hi = ^bus.fifo_data[MULTI_POP-1:MAX_LEN];

  // Pack the first len head bytes into the instruction word, zero above.
  function automatic logic [IW-1:0] assemble_instr(
    input logic [MULTI_POP-1:0][DATA_WIDTH-1:0] bytes,
    input logic [2:0]                            len
  );
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (3'(i) < len) r[i*DATA_WIDTH +: DATA_WIDTH] = bytes[i];
    end
    return r;
  endfunction

  // Saturating 32-bit increment used by the performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Length decode and load qualification from the current FIFO head view.
  always_comb begin
    len_dec    = {1'b0, bus.fifo_data[0][1:0]} + 3'd1;
    len_cnt    = CNT_W'(len_dec);
    head_avail = (bus.fifo_ready_cnt != '0);
    slot_free  = !valid_q || bus.instr_ready;
    load       = (state_q == RUN) && !bus.flush && head_avail &&
                 (bus.fifo_ready_cnt >= len_cnt) && slot_free;
    starve     = (state_q == RUN) && !bus.flush && slot_free &&
                 (!head_avail || (bus.fifo_ready_cnt < len_cnt));
  end

  // Next-state, pop count and output register next values.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    len_d    = len_q;
    poll_cnt = '0;
    case (state_q)
      RUN: begin
        if (bus.flush) begin
          // flush wins over load: drop the held instruction, empty the FIFO
          poll_cnt = bus.fifo_ready_cnt;
          valid_d  = 1'b0;
          state_d  = DRAIN;
        end else if (load) begin
          poll_cnt = len_cnt;
          data_d   = assemble_instr(bus.fifo_data, len_dec);
          len_d    = len_dec;
          valid_d  = 1'b1;
        end else if (bus.instr_ready) begin
          valid_d  = 1'b0;
        end
      end
      DRAIN: begin
        // anything upstream pushes while draining is thrown away
        poll_cnt = bus.fifo_ready_cnt;
        valid_d  = 1'b0;
        if (!bus.flush && (bus.fifo_ready_cnt == '0)) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
    endcase
    // no pops while held in reset, whatever the FIFO shows
    if (rst) poll_cnt = '0;
  end

  // State and output registers; reset clears the held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      len_q   <= len_d;
    end
  end

  assign bus.fifo_poll_cnt = poll_cnt;
  assign bus.instr_valid   = valid_q;
  assign bus.instr_data    = data_q;
  assign bus.instr_len     = len_q;

`ifdef INSTR_ALIGNER_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] icount_q, icount_d;

  // Count starvation cycles and loaded instructions, saturating.
  always_comb begin
    stall_d  = stall_q;
    icount_d = icount_q;
    if (starve) stall_d  = sat_inc(stall_q);
    if (load)   icount_d = sat_inc(icount_q);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      icount_q <= '0;
    end else begin
      stall_q  <= stall_d;
      icount_q <= icount_d;
    end
  end

  assign stall_cycles = stall_q;
  assign instr_count  = icount_q;
`else
  logic unused_perf;
  assign unused_perf = starve;
`endif

  // The aligner must never ask the FIFO for more entries than it holds.
  a_poll_le_ready: assert property (
    @(posedge clk) disable iff (rst) bus.fifo_poll_cnt <= bus.fifo_ready_cnt
  );

endmodule

// File: tb/tb_instr_byte_aligner.sv
// Directed bench for instr_byte_aligner: reset, partial instruction wait,
// mixed-length back-to-back loads, backpressure, flush/drain, reset mid-op
// and (with INSTR_ALIGNER_PERF_EN) the performance counters.
module tb_instr_byte_aligner;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  instr_byte_aligner_if #(.DATA_WIDTH(8), .MULTI_POP(8), .MAX_LEN(4)) bus ();

`ifdef INSTR_ALIGNER_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] instr_count;
`endif

  instr_byte_aligner #(.DATA_WIDTH(8), .MULTI_POP(8), .MAX_LEN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef INSTR_ALIGNER_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .instr_count  (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs are then driven at posedge+1, checks at posedge+2
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fifo(input int cnt, input logic [63:0] bytes);
    bus.fifo_ready_cnt = 3'(cnt);
    bus.fifo_data      = bytes;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.instr_ready = 1'b1;
    set_fifo(5, 64'h0000_0000_0000_0000);

    // reset holds pops off and clears the output register
    step(); settle();
    chk("rst_poll", 64'(bus.fifo_poll_cnt), 64'd0);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_data", 64'(bus.instr_data), 64'd0);
    chk("rst_len", 64'(bus.instr_len), 64'd0);
    step();
    rst = 1'b0; settle();
    chk("post_rst_poll", 64'(bus.fifo_poll_cnt), 64'd1);
    step();
    chk("post_rst_valid", 64'(bus.instr_valid), 64'd1);
    chk("post_rst_len", 64'(bus.instr_len), 64'd1);
    set_fifo(0, 64'h0); settle();
    chk("empty_poll", 64'(bus.fifo_poll_cnt), 64'd0);
    step();
    chk("accept_clear_valid", 64'(bus.instr_valid), 64'd0);

    // L=4 instruction only 3 bytes visible: wait, then load all 4
    set_fifo(3, 64'h0000_0000_3322_1103); settle();
    chk("partial_poll", 64'(bus.fifo_poll_cnt), 64'd0);
    step();
    chk("partial_valid", 64'(bus.instr_valid), 64'd0);
    set_fifo(4, 64'h0000_0000_3322_1103); settle();
    chk("full4_poll", 64'(bus.fifo_poll_cnt), 64'd4);
    step();
    chk("full4_valid", 64'(bus.instr_valid), 64'd1);
    chk("full4_len", 64'(bus.instr_len), 64'd4);
    chk("full4_data", 64'(bus.instr_data), 64'h3322_1103);
    set_fifo(0, 64'h0);
    step();

    // back-to-back lengths 1, 2, 3
    set_fifo(6, 64'h0000_CCBB_02AA_0100); settle();
    chk("seq1_poll", 64'(bus.fifo_poll_cnt), 64'd1);
    step();
    chk("seq1_len", 64'(bus.instr_len), 64'd1);
    chk("seq1_data", 64'(bus.instr_data), 64'h0000_0000);
    set_fifo(5, 64'h0000_00CC_BB02_AA01); settle();
    chk("seq2_poll", 64'(bus.fifo_poll_cnt), 64'd2);
    step();
    chk("seq2_len", 64'(bus.instr_len), 64'd2);
    chk("seq2_data", 64'(bus.instr_data), 64'h0000_AA01);
    set_fifo(3, 64'h0000_0000_00CC_BB02); settle();
    chk("seq3_poll", 64'(bus.fifo_poll_cnt), 64'd3);
    step();
    chk("seq3_valid", 64'(bus.instr_valid), 64'd1);
    chk("seq3_len", 64'(bus.instr_len), 64'd3);
    chk("seq3_data", 64'(bus.instr_data), 64'h00CC_BB02);

    // backpressure: hold for 3 cycles, then accept and load together
    bus.instr_ready = 1'b0;
    set_fifo(2, 64'h0000_0000_0000_5501);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_poll", 64'(bus.fifo_poll_cnt), 64'd0);
      chk("stall_data", 64'(bus.instr_data), 64'h00CC_BB02);
      chk("stall_valid", 64'(bus.instr_valid), 64'd1);
      step();
    end
    bus.instr_ready = 1'b1; settle();
    chk("accept_load_poll", 64'(bus.fifo_poll_cnt), 64'd2);
    step();
    chk("accept_load_valid", 64'(bus.instr_valid), 64'd1);
    chk("accept_load_len", 64'(bus.instr_len), 64'd2);
    chk("accept_load_data", 64'(bus.instr_data), 64'h0000_5501);

    // flush with a held instruction and 5 bytes waiting
    bus.instr_ready = 1'b0;
    bus.flush = 1'b1;
    set_fifo(5, 64'h0000_0011_2233_4400); settle();
    chk("flush_poll", 64'(bus.fifo_poll_cnt), 64'd5);
    step();
    chk("flush_valid", 64'(bus.instr_valid), 64'd0);
    bus.flush = 1'b0;
    bus.instr_ready = 1'b1;
    set_fifo(2, 64'h0000_0000_0000_7700); settle();
    chk("drain_poll2", 64'(bus.fifo_poll_cnt), 64'd2);
    step();
    chk("drain_valid", 64'(bus.instr_valid), 64'd0);
    set_fifo(1, 64'h0000_0000_0000_0000); settle();
    chk("drain_poll1", 64'(bus.fifo_poll_cnt), 64'd1);
    step();
    chk("drain_valid2", 64'(bus.instr_valid), 64'd0);
    set_fifo(0, 64'h0); settle();
    chk("drain_empty_poll", 64'(bus.fifo_poll_cnt), 64'd0);
    step();
    set_fifo(2, 64'h0000_0000_0000_6600); settle();
    chk("rerun_poll", 64'(bus.fifo_poll_cnt), 64'd1);
    step();
    chk("rerun_valid", 64'(bus.instr_valid), 64'd1);
    chk("rerun_data", 64'(bus.instr_data), 64'h0000_0000);

    // reset while holding an instruction discards it
    bus.instr_ready = 1'b0;
    set_fifo(0, 64'h0);
    rst = 1'b1; settle();
    chk("rst_mid_poll", 64'(bus.fifo_poll_cnt), 64'd0);
    step();
    chk("rst_mid_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_mid_len", 64'(bus.instr_len), 64'd0);
    rst = 1'b0;
    bus.instr_ready = 1'b1;

`ifdef INSTR_ALIGNER_PERF_EN
    // counters were cleared by the reset edge above; 4 starved edges then a load
    chk("perf_rst_stall", 64'(stall_cycles), 64'd0);
    chk("perf_rst_count", 64'(instr_count), 64'd0);
    for (int i = 0; i < 4; i++) step();
    set_fifo(1, 64'h0000_0000_0000_0000);
    step();
    chk("perf_stall", 64'(stall_cycles), 64'd4);
    chk("perf_count", 64'(instr_count), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_byte_aligner.md
Name: instr_byte_aligner

Overview:
- Consumer stage directly downstream of the multi-pop instruction-byte FIFO.
- Each cycle it inspects the FIFO's visible head entries and decodes the length of the instruction at the head from byte 0.
- Once every byte of that instruction is visible, it pops exactly that many entries in one cycle and registers the assembled instruction toward decode over a valid/ready handshake.
- Also drains the FIFO on a pipeline flush.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (one instruction byte).
- MULTI_POP, 8, number of FIFO head entries visible per cycle; must be greater than MAX_LEN.
- MAX_LEN, 4, maximum instruction length in entries; fixed by the 2-bit length encoding and must equal 4.
- CNT_W, $clog2(MULTI_POP), width of the pop/ready counts.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- fifo_data  input  DATA_WIDTH x MULTI_POP  FIFO head entries; index 0 is oldest.
- fifo_ready_cnt  input  CNT_W  number of valid entries in fifo_data.
- fifo_poll_cnt  output  CNT_W  entries to pop at this edge (combinational).
- flush  input  1  discard the pending instruction and all FIFO contents.
- instr_data  output  MAX_LEN*DATA_WIDTH  assembled instruction; byte i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- instr_len  output  3  instruction length, 1..4.
- instr_valid  output  1  instr_data/instr_len hold a valid instruction.
- instr_ready  input  1  decode accepts the instruction this cycle.

Behaviour:
- Length decode: L = fifo_data[0][1:0] + 1, so encodings 00..11 give L = 1..4.
  - Valid only when fifo_ready_cnt >= 1.
- FIFO contract:
  - fifo_data/fifo_ready_cnt reflect FIFO state after the previous edge.
  - The FIFO applies fifo_poll_cnt at the current edge.
  - fifo_poll_cnt must never exceed fifo_ready_cnt; this is asserted.
- State machine with two states, RUN and DRAIN; reset state is RUN.
- RUN:
  - Output slot free = !instr_valid || instr_ready.
  - Load when: !flush, fifo_ready_cnt >= 1, fifo_ready_cnt >= L, and slot free.
  - On load:
    - fifo_poll_cnt = L.
    - Next edge: instr_data bytes 0..L-1 = fifo_data[0..L-1], bytes L..3 = 0; instr_len = L; instr_valid = 1.
  - Otherwise fifo_poll_cnt = 0.
  - instr_valid clears at the edge where instr_ready=1 and no new load occurs.
  - A partially visible instruction (fifo_ready_cnt < L) waits with no pop and no partial consumption.
  - Back-to-back: accept and load in the same cycle gives one instruction per cycle with no bubble.
  - instr_valid=1 && !instr_ready: instr_data/instr_len hold stable and fifo_poll_cnt = 0.
- flush (either state, takes priority over load):
  - fifo_poll_cnt = fifo_ready_cnt.
  - instr_valid -> 0 next edge.
  - State -> DRAIN.
- DRAIN:
  - fifo_poll_cnt = fifo_ready_cnt every cycle; instr_valid stays 0.
  - Go to RUN at the edge where !flush && fifo_ready_cnt == 0.
  - Bytes pushed by upstream during DRAIN are discarded.
- Reset: instr_valid=0, instr_data=0, instr_len=0, state=RUN, and fifo_poll_cnt forced to 0 while rst=1.
- Reset mid-operation discards the held instruction.
- instr_data/instr_len are don't-care when instr_valid=0, but must stay at their last value (no X propagation).

Optional Feature:
- Macro: INSTR_ALIGNER_PERF_EN.
- When defined, adds output stall_cycles (32 bits):
  - Increments on every RUN cycle where !flush, the slot is free, and either fifo_ready_cnt == 0 or fifo_ready_cnt < L (starvation).
  - Saturates at 2^32-1 and resets to 0.
- Also adds output instr_count (32 bits), incremented on each load; saturates and resets to 0.
- When undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset with fifo_ready_cnt=5 and rst=1 -> fifo_poll_cnt=0 and instr_valid=0; one cycle after rst drops, a load occurs.
- fifo_data[0]=0x03 (L=4), fifo_ready_cnt=3, instr_ready=1 -> fifo_poll_cnt=0 and no load; at fifo_ready_cnt=4 -> fifo_poll_cnt=4; next cycle instr_len=4, instr_data = {b3,b2,b1,0x03}.
- Head sequence 0x00, 0x01, 0xAA, 0x02, 0xBB, 0xCC with fifo_ready_cnt=6 and instr_ready=1 -> pops of 1, 2, 3 on consecutive cycles.
  - instr_len = 1, 2, 3.
  - Lengths 1 and 2 have zero-filled upper bytes.
- instr_valid=1, instr_ready=0 for 3 cycles -> instr_data stable and fifo_poll_cnt=0 throughout; instr_ready=1 -> a new load happens in the same cycle.
- flush=1 with instr_valid=1 and fifo_ready_cnt=5 -> fifo_poll_cnt=5 and instr_valid=0 next cycle.
  - Two further pushes then appear; each is popped.
  - RUN is re-entered only after fifo_ready_cnt=0 with flush low.
- Under INSTR_ALIGNER_PERF_EN: 4 cycles with fifo_ready_cnt=0, then one L=1 load -> stall_cycles=4 and instr_count=1.
